// File: rtl/wsa_adc_interface.sv
// ---------------------------------------------------------------------------
// wsa_adc_interface
//
// Receive-side front end between the two 12-bit ADC channels and DDC
// channel 0.  Each ADC sample is widened to 16 bits and registered.  Its DC
// offset is then removed, using either a fixed offset or a closed-loop
// accumulator that tracks the mean.  The corrected samples are routed onto
// the DDC I/Q inputs through a registered mux.  A per-ADC level (RSSI)
// estimate and an over-range counter run alongside the datapath.  The
// serial-bus setting registers (RX mux, ADC offsets, DC-loop enable) live
// inside this block.
//
// Ports
//   clock          sole clock, rising edge
//   reset          synchronous, active-high, clears every register
//   enable         datapath/RSSI registers advance only when high
//   serial_addr    setting-register address
//   serial_data    setting-register write data
//   serial_strobe  one-cycle write strobe
//   rx_a_a         ADC0 sample, 12-bit two's complement
//   rx_b_a         ADC1 sample, 12-bit two's complement
//   rssi_0         ADC0 level report {over_count[15:0], level[15:0]}
//   rssi_1         ADC1 level report, same format
//   ddc0_in_i      selected I sample to the DDC
//   ddc0_in_q      selected Q sample to the DDC
//   rx_numchan     RX mux register bits [3:0]
// ---------------------------------------------------------------------------
module wsa_adc_interface #(
  parameter int RX_MUX_ADDR       = 38,
  parameter int ADC_OFFSET_0_ADDR = 46,
  parameter int ADC_OFFSET_1_ADDR = 47,
  parameter int DCOFF_EN_ADDR     = 55
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic [11:0] rx_a_a,
  input  logic [11:0] rx_b_a,
  output logic [31:0] rssi_0,
  output logic [31:0] rssi_1,
  output logic [15:0] ddc0_in_i,
  output logic [15:0] ddc0_in_q,
  output logic [3:0]  rx_numchan
);

  // -------------------------------------------------------------------------
  // Shared setting registers: RX mux and DC-loop enable.
  // The ADC offsets are per channel and live inside the channel blocks.
  // -------------------------------------------------------------------------
  logic [7:0] rx_mux_d, rx_mux_q;
  logic [1:0] dcoff_en_d, dcoff_en_q;

  logic wr_rx_mux;
  logic wr_dcoff_en;

  // Only the low half of the write data carries information for this block.
  logic unused_serial_bits;
  assign unused_serial_bits = ^serial_data[31:16];

  assign wr_rx_mux   = serial_strobe && (serial_addr == 7'(RX_MUX_ADDR));
  assign wr_dcoff_en = serial_strobe && (serial_addr == 7'(DCOFF_EN_ADDR));

  always_comb begin
    rx_mux_d   = rx_mux_q;
    dcoff_en_d = dcoff_en_q;
    if (wr_rx_mux) begin
      rx_mux_d = serial_data[7:0];
    end
    if (wr_dcoff_en) begin
      dcoff_en_d = serial_data[1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_mux_q   <= '0;
      dcoff_en_q <= '0;
    end else begin
      rx_mux_q   <= rx_mux_d;
      dcoff_en_q <= dcoff_en_d;
    end
  end

  // Corrected samples and level reports gathered from both channels.
  logic [1:0][15:0] corr_all;
  logic [1:0][31:0] rssi_all;

  // -------------------------------------------------------------------------
  // Per-channel datapath: widen, offset removal, level measurement.
  // -------------------------------------------------------------------------
  for (genvar n = 0; n < 2; n++) begin : g_ch
    localparam int OFF_ADDR = (n == 0) ? ADC_OFFSET_0_ADDR : ADC_OFFSET_1_ADDR;

    logic [11:0] raw;
    logic        wr_offset;

    logic [15:0] offset_d, offset_q;
    logic [15:0] adc_w_d, adc_w_q;
    logic [15:0] corr_d, corr_q;
    logic [31:0] acc_d, acc_q;
    logic [25:0] levacc_d, levacc_q;
    logic [15:0] over_d, over_q;

    logic [15:0] ref_val;
    logic [16:0] diff;
    logic [15:0] sat;
    logic [11:0] neg_raw;
    logic [10:0] abs_val;
    logic        over_range;

    assign raw       = (n == 0) ? rx_a_a : rx_b_a;
    assign wr_offset = serial_strobe && (serial_addr == 7'(OFF_ADDR));

    always_comb begin
      offset_d   = offset_q;
      adc_w_d    = adc_w_q;
      corr_d     = corr_q;
      acc_d      = acc_q;
      levacc_d   = levacc_q;
      over_d     = over_q;
      ref_val    = offset_q;
      diff       = '0;
      sat        = '0;
      neg_raw    = '0;
      abs_val    = '0;
      over_range = 1'b0;

      if (wr_offset) begin
        offset_d = serial_data[15:0];
      end

      // Stage 2 subtracts either the fixed offset or the tracked mean held
      // in the top half of the accumulator.  The difference is taken at
      // 17 bits and clamped back into the signed 16-bit range.
      ref_val = dcoff_en_q[n] ? acc_q[31:16] : offset_q;
      diff    = {adc_w_q[15], adc_w_q} - {ref_val[15], ref_val};
      if (diff[16] != diff[15]) begin
        sat = diff[16] ? 16'h8000 : 16'h7FFF;
      end else begin
        sat = diff[15:0];
      end

      // Level estimate uses the magnitude of the raw 12-bit sample; the
      // most negative code has no positive twin, so it folds to 2047.
      neg_raw = ~raw + 12'd1;
      if (raw == 12'h800) begin
        abs_val = 11'h7FF;
      end else if (raw[11]) begin
        abs_val = neg_raw[10:0];
      end else begin
        abs_val = raw[10:0];
      end
      over_range = (raw == 12'h7FF) || (raw == 12'h800);

      if (enable) begin
        adc_w_d  = {raw[11], raw, 3'b000};
        corr_d   = sat;
        levacc_d = levacc_q + 26'(abs_val) - 26'(levacc_q[25:10]);
        if (over_range && (over_q != 16'hFFFF)) begin
          over_d = over_q + 16'd1;
        end
      end

      // A fresh fixed offset also seeds the loop accumulator so that a
      // later switch to closed-loop starts from the programmed estimate.
      if (wr_offset) begin
        acc_d = {serial_data[15:0], 16'h0000};
      end else if (enable && dcoff_en_q[n]) begin
        acc_d = acc_q + {{16{sat[15]}}, sat};
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        offset_q <= '0;
        adc_w_q  <= '0;
        corr_q   <= '0;
        acc_q    <= '0;
        levacc_q <= '0;
        over_q   <= '0;
      end else begin
        offset_q <= offset_d;
        adc_w_q  <= adc_w_d;
        corr_q   <= corr_d;
        acc_q    <= acc_d;
        levacc_q <= levacc_d;
        over_q   <= over_d;
      end
    end

    assign corr_all[n] = corr_q;
    assign rssi_all[n] = {over_q, levacc_q[25:10]};
  end

  // -------------------------------------------------------------------------
  // Stage 3: route corrected samples onto the DDC I/Q inputs.
  // Source codes 2 and 3 feed zeros.
  // -------------------------------------------------------------------------
  function automatic logic [15:0] pick_source(input logic [1:0]       code,
                                              input logic [1:0][15:0] src);
    logic [15:0] result;
    case (code)
      2'd0:    result = src[0];
      2'd1:    result = src[1];
      default: result = 16'h0000;
    endcase
    return result;
  endfunction

  logic [15:0] ddc_i_d, ddc_i_q;
  logic [15:0] ddc_q_d, ddc_q_q;

  always_comb begin
    ddc_i_d = ddc_i_q;
    ddc_q_d = ddc_q_q;
    if (enable) begin
      ddc_i_d = pick_source(rx_mux_q[5:4], corr_all);
      ddc_q_d = pick_source(rx_mux_q[7:6], corr_all);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ddc_i_q <= '0;
      ddc_q_q <= '0;
    end else begin
      ddc_i_q <= ddc_i_d;
      ddc_q_q <= ddc_q_d;
    end
  end

  assign ddc0_in_i  = ddc_i_q;
  assign ddc0_in_q  = ddc_q_q;
  assign rx_numchan = rx_mux_q[3:0];
  assign rssi_0     = rssi_all[0];
  assign rssi_1     = rssi_all[1];

endmodule

// File: tb/tb_wsa_adc_interface.sv
// ---------------------------------------------------------------------------
// tb_wsa_adc_interface
//
// Directed bench for wsa_adc_interface.  A table of setting/sample records
// with hand-computed DDC outputs drives the main routing and offset paths.
// Hand-written sequences then cover pipeline latency, the closed DC loop,
// RSSI counting with enable held low, level convergence, address decode
// and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_wsa_adc_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic [11:0] rx_a_a;
  logic [11:0] rx_b_a;
  logic [31:0] rssi_0;
  logic [31:0] rssi_1;
  logic [15:0] ddc0_in_i;
  logic [15:0] ddc0_in_q;
  logic [3:0]  rx_numchan;

  int checks   = 0;
  int failures = 0;

  // 100 MHz free-running clock.
  always #5 clock = ~clock;

  wsa_adc_interface dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .rx_a_a        (rx_a_a),
    .rx_b_a        (rx_b_a),
    .rssi_0        (rssi_0),
    .rssi_1        (rssi_1),
    .ddc0_in_i     (ddc0_in_i),
    .ddc0_in_q     (ddc0_in_q),
    .rx_numchan    (rx_numchan)
  );

  typedef struct {
    logic [7:0]  mux;
    logic [15:0] off0;
    logic [15:0] off1;
    logic [11:0] rx_a;
    logic [11:0] rx_b;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    logic [3:0]  exp_nc;
  } vec_t;

  vec_t vecs [6];

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic serialWrite(input logic [6:0] addr, input logic [31:0] data);
    serial_addr   = addr;
    serial_data   = data;
    serial_strobe = 1'b1;
    tick(1);
    serial_strobe = 1'b0;
  endtask

  task automatic doReset();
    reset  = 1'b1;
    rx_a_a = '0;
    rx_b_a = '0;
    tick(2);
    reset  = 1'b0;
  endtask

  // Program settings for one table record, present its samples, and let
  // them flow through all three pipeline stages.
  task automatic applyStimulus(input vec_t v);
    serialWrite(7'd38, {24'h0, v.mux});
    serialWrite(7'd46, {16'h0, v.off0});
    serialWrite(7'd47, {16'h0, v.off1});
    rx_a_a = v.rx_a;
    rx_b_a = v.rx_b;
    tick(4);
  endtask

  initial begin
    logic [15:0] prev_i;
    logic [15:0] lvl;
    int          rises;

    reset         = 1'b1;
    enable        = 1'b1;
    serial_addr   = '0;
    serial_data   = '0;
    serial_strobe = 1'b0;
    rx_a_a        = '0;
    rx_b_a        = '0;

    // Reset state
    doReset();
    checkOutput("reset_ddc_i",   32'(ddc0_in_i),  32'h0);
    checkOutput("reset_ddc_q",   32'(ddc0_in_q),  32'h0);
    checkOutput("reset_rssi_0",  rssi_0,          32'h0);
    checkOutput("reset_numchan", 32'(rx_numchan), 32'h0);

    // Routing / offset table: mux, off0, off1, rx_a, rx_b, exp_i, exp_q, exp_nc
    vecs[0] = '{8'h90, 16'h0000, 16'h0000, 12'h000, 12'h100, 16'h0800, 16'h0000, 4'h0};
    vecs[1] = '{8'h00, 16'h0100, 16'h0000, 12'h040, 12'h000, 16'h0100, 16'h0100, 4'h0};
    vecs[2] = '{8'h00, 16'h7FFF, 16'h0000, 12'h800, 12'h000, 16'h8000, 16'h8000, 4'h0};
    vecs[3] = '{8'h13, 16'h8000, 16'h0000, 12'h7FF, 12'h123, 16'h0918, 16'h7FFF, 4'h3};
    vecs[4] = '{8'hE5, 16'h0000, 16'h0000, 12'h321, 12'h456, 16'h0000, 16'h0000, 4'h5};
    vecs[5] = '{8'h40, 16'hFF00, 16'h0010, 12'hF00, 12'h001, 16'hF900, 16'hFFF8, 4'h0};

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_i", i),  32'(ddc0_in_i),  32'(vecs[i].exp_i));
      checkOutput($sformatf("vec%0d_q", i),  32'(ddc0_in_q),  32'(vecs[i].exp_q));
      checkOutput($sformatf("vec%0d_nc", i), 32'(rx_numchan), 32'(vecs[i].exp_nc));
    end

    // Latency: a new ADC1 sample appears on I on the third edge only.
    serialWrite(7'd38, 32'h90);
    serialWrite(7'd46, 32'h0);
    serialWrite(7'd47, 32'h0);
    rx_b_a = 12'h100;
    tick(4);
    rx_b_a = 12'h200;
    tick(2);
    checkOutput("latency_edge2", 32'(ddc0_in_i), 32'h0800);
    tick(1);
    checkOutput("latency_edge3", 32'(ddc0_in_i), 32'h1000);

    // Closed DC loop on ADC0: starts at 0x0400 and decays without rising.
    doReset();
    rx_a_a = 12'h080;
    serialWrite(7'd55, 32'h1);
    tick(3);
    checkOutput("dc_start", 32'(ddc0_in_i), 32'h0400);
    prev_i = ddc0_in_i;
    rises  = 0;
    for (int c = 0; c < 30000; c++) begin
      tick(1);
      if (ddc0_in_i > prev_i || ddc0_in_i[15]) rises++;
      prev_i = ddc0_in_i;
    end
    checkOutput("dc_monotonic", 32'(rises), 32'h0);
    checkOutput("dc_decayed", 32'(ddc0_in_i >= 16'h0200 && ddc0_in_i <= 16'h02C0), 32'h1);

    // RSSI: ten full-scale samples, then enable low freezes everything.
    doReset();
    rx_a_a = 12'h7FF;
    tick(10);
    checkOutput("rssi_count10", rssi_0, 32'h000A_0013);
    checkOutput("rssi_1_idle",  rssi_1, 32'h0);
    checkOutput("ddc_fullscale", 32'(ddc0_in_i), 32'h3FF8);
    enable = 1'b0;
    tick(5);
    checkOutput("hold_rssi_0", rssi_0, 32'h000A_0013);
    checkOutput("hold_ddc_i",  32'(ddc0_in_i), 32'h3FF8);
    checkOutput("hold_ddc_q",  32'(ddc0_in_q), 32'h3FF8);
    enable = 1'b1;
    tick(1);
    checkOutput("resume_count", 32'(rssi_0[31:16]), 32'd11);

    // Level convergence with a negative constant of magnitude 0x400.
    doReset();
    rx_a_a = 12'hC00;
    tick(10000);
    lvl = rssi_0[15:0];
    checkOutput("level_conv", 32'(lvl >= 16'h03FF && lvl <= 16'h0401), 32'h1);
    checkOutput("level_no_over", 32'(rssi_0[31:16]), 32'h0);

    // Address decode for the RX mux register.
    doReset();
    serialWrite(7'd39, 32'h2);
    checkOutput("wrong_addr_nc", 32'(rx_numchan), 32'h0);
    serialWrite(7'd38, 32'h2);
    checkOutput("right_addr_nc", 32'(rx_numchan), 32'h2);

    // Mid-stream reset and pipeline refill.
    rx_a_a = 12'h123;
    tick(4);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_reset_i",    32'(ddc0_in_i),  32'h0);
    checkOutput("mid_reset_q",    32'(ddc0_in_q),  32'h0);
    checkOutput("mid_reset_r0",   rssi_0,          32'h0);
    checkOutput("mid_reset_r1",   rssi_1,          32'h0);
    checkOutput("mid_reset_nc",   32'(rx_numchan), 32'h0);
    reset = 1'b0;
    tick(2);
    checkOutput("refill_edge2", 32'(ddc0_in_i), 32'h0);
    tick(1);
    checkOutput("refill_edge3", 32'(ddc0_in_i), 32'h0918);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
